// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered demultiplexer.
// Optional feature macro: DEMUX_HOLD_LANES_EN (see demux_core / demux_reg).
package demux_pkg;

  localparam int DEMUX_N_DEF = 2;
  localparam int DEMUX_S_DEF = 1;

  // Widest lane count the one-hot helper can produce; callers narrow the result.
  localparam int DEMUX_MAX_S = 6;
  localparam int DEMUX_MAX_L = 1 << DEMUX_MAX_S;

  function automatic int unsigned lanes(input int unsigned s);
    return 32'd1 << s;
  endfunction

  // One-hot of sel over 2**s lanes; zero if sel is outside that range.
  function automatic logic [DEMUX_MAX_L-1:0] onehot(input int unsigned sel,
                                                    input int unsigned s);
    if (sel >= lanes(s)) return '0;
    return DEMUX_MAX_L'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_core.sv
// Combinational next-state for the demux: lane contents and one-hot valid.
// With DEMUX_HOLD_LANES_EN, unselected lanes keep prev_* instead of zero.
module demux_core
  import demux_pkg::*;
#(
  parameter int N = DEMUX_N_DEF,
  parameter int S = DEMUX_S_DEF
) (
  input  logic [N-1:0]                  a_i,
  input  logic [S-1:0]                  select_i,
`ifdef DEMUX_HOLD_LANES_EN
  input  logic [lanes(S)-1:0][N-1:0]    prev_result_i,
  input  logic [lanes(S)-1:0]           prev_valid_i,
`endif
  output logic [lanes(S)-1:0][N-1:0]    result_o,
  output logic [lanes(S)-1:0]           valid_o
);

  localparam int L = lanes(S);

  logic [L-1:0] oh;
  assign oh = L'(onehot(32'(select_i), S));

  // Per-lane steering: selected lane takes a_i, others zero or hold.
  for (genvar k = 0; k < L; k++) begin : g_lane
`ifdef DEMUX_HOLD_LANES_EN
    assign result_o[k] = oh[k] ? a_i : prev_result_i[k];
    assign valid_o[k]  = oh[k] | prev_valid_i[k];
`else
    assign result_o[k] = oh[k] ? a_i : '0;
    assign valid_o[k]  = oh[k];
`endif
  end

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2**S demultiplexer: one cycle latency, sync active-high
// reset (priority over en), en=0 holds all outputs.
// Optional macro DEMUX_HOLD_LANES_EN: unselected lanes and valid bits are
// retained rather than cleared on an enabled edge.
module demux_reg
  import demux_pkg::*;
#(
  parameter int N = DEMUX_N_DEF,
  parameter int S = DEMUX_S_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N-1:0]                  a,
  input  logic [S-1:0]                  select,
  output logic [lanes(S)-1:0][N-1:0]    result,
  output logic [lanes(S)-1:0]           lane_valid
);

  localparam int L = lanes(S);

  if (S < 1 || S > DEMUX_MAX_S) begin : g_bad_s
    $error("demux_reg: S out of supported range");
  end
  if (N < 1) begin : g_bad_n
    $error("demux_reg: N must be at least 1");
  end

  logic [L-1:0][N-1:0] result_q, result_d;
  logic [L-1:0]        lane_valid_q, lane_valid_d;

  demux_core #(.N(N), .S(S)) u_core (
    .a_i           (a),
    .select_i      (select),
`ifdef DEMUX_HOLD_LANES_EN
    .prev_result_i (result_q),
    .prev_valid_i  (lane_valid_q),
`endif
    .result_o      (result_d),
    .valid_o       (lane_valid_d)
  );

  // Output registers: reset clears, enable loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q     <= '0;
      lane_valid_q <= '0;
    end else if (en) begin
      result_q     <= result_d;
      lane_valid_q <= lane_valid_d;
    end
  end

  assign result     = result_q;
  assign lane_valid = lane_valid_q;

endmodule

// File: tb/tb_demux_reg.sv
// Self-checking bench for demux_reg (N=2, S=1): directed plan plus random
// stimulus against an array-based reference model.
module tb_demux_reg;

  localparam int N = 2;
  localparam int S = 1;
  localparam int L = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic [N-1:0]       a = '0;
  logic [S-1:0]       select = '0;
  logic [L-1:0][N-1:0] result;
  logic [L-1:0]       lane_valid;

  // Reference state: one integer per lane plus a valid bitmask.
  int m_lane [L];
  int m_vld;

  int n_vec = 0;
  int n_err = 0;

  demux_reg #(.N(N), .S(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .select     (select),
    .result     (result),
    .lane_valid (lane_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < L; k++)
      chk($sformatf("%s.lane%0d", tag, k), 32'(result[k]), m_lane[k]);
    chk({tag, ".valid"}, 32'(lane_valid), m_vld);
  endtask

  // Apply one clock with the given inputs, advance the model, check at negedge.
  task automatic cyc(input string tag, input bit r, input bit e,
                     input int av, input int sv);
    rst    = r;
    en     = e;
    a      = N'(av);
    select = S'(sv);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < L; k++) m_lane[k] = 0;
      m_vld = 0;
    end else if (e) begin
`ifdef DEMUX_HOLD_LANES_EN
      m_lane[sv] = av;
      m_vld = m_vld | (1 << sv);
`else
      for (int k = 0; k < L; k++) m_lane[k] = (k == sv) ? av : 0;
      m_vld = 1 << sv;
`endif
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    for (int k = 0; k < L; k++) m_lane[k] = 0;
    m_vld = 0;
    @(negedge clk);

    // Reset with live data on the inputs.
    cyc("rst0", 1, 0, 3, 1);
    cyc("rst1", 1, 1, 3, 1);

    // Lane sweeps.
    for (int v = 0; v < 4; v++) cyc("sweep0", 0, 1, v, 0);
    for (int v = 0; v < 4; v++) cyc("sweep1", 0, 1, v, 1);

    // Enable hold.
    cyc("load", 0, 1, 2, 1);
    for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 3, 0);

    // Reset priority over enable mid-stream, then first update.
    cyc("rstpri", 1, 1, 3, 0);
    cyc("postrst", 0, 1, 3, 0);

`ifdef DEMUX_HOLD_LANES_EN
    cyc("rst_h", 1, 0, 0, 0);
    cyc("hold_w0", 0, 1, 1, 0);
    cyc("hold_w1", 0, 1, 2, 1);
    cyc("hold_rst", 1, 0, 0, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(19) == 0), ($urandom_range(3) != 0),
          int'($urandom_range(3)), int'($urandom_range(1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
Registered 1-to-2**S demultiplexer.
- Routes an N-bit input word to the output lane chosen by `select`; unselected lanes are forced to zero.
- Output is registered: one clock of latency, synchronous active-high reset.
- Used as a generic fan-out utility in the datapath, e.g. to steer a bus word to one of several consumers.

Parameters:
N, 2, data width of the input word and of each output lane (N >= 1)
S, 1, select width; number of output lanes L = 2**S (S >= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  update enable; when low, all registered outputs hold
a  input  N  data word to route
select  input  S  destination lane index, unsigned
result  output  L x N (packed [L-1:0][N-1:0])  lane array; lane k = result[k]
lane_valid  output  L  one-hot flag; bit k high when lane k holds routed data

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All state updates on the rising edge of clk; there are no combinational paths from inputs to outputs.
- Reset: at any edge with rst=1, result = all zeros and lane_valid = 0. rst has priority over en.
- Normal operation: at an edge with rst=0 and en=1:
  - result[select] <= a
  - result[k] <= 0 for every k != select
  - lane_valid <= one-hot(select)
- Hold: at an edge with rst=0 and en=0, result and lane_valid keep their previous values.
- Latency: exactly 1 cycle from a/select sampled to result visible. Back-to-back updates are allowed every cycle; throughput is one word per clock.
- Select range: select is always in range because L = 2**S. No out-of-range case exists.
- Data rules:
  - a = 0 is routed like any other value: the selected lane reads 0, but lane_valid still flags it.
  - No arithmetic and no width conversion; lanes are bit-exact copies of a.
- Reset asserted mid-stream clears all lanes on that same edge. The first post-reset update requires en=1.
- X on select while en=1 is not a supported condition. Simulation may propagate X.

Optional Feature:
Macro DEMUX_HOLD_LANES_EN.
- Defined: unselected lanes retain their previous contents instead of being zeroed. Only result[select] is written on an enabled edge.
  - lane_valid becomes sticky: bit select is set, other bits are unchanged.
  - Reset still clears everything.
- Undefined (default): zero-fill behaviour as specified above.

Decomposition:
- Package demux_pkg holds:
  - default parameter constants DEMUX_N_DEF = 2 and DEMUX_S_DEF = 1;
  - a function lanes(S) returning 2**S;
  - a function onehot(sel, S) returning the L-bit one-hot vector.
- One natural sub-module: demux_core. It is purely combinational and takes a, select (plus previous result when DEMUX_HOLD_LANES_EN is defined) to produce next-state lanes and the one-hot vector.
- demux_reg wraps demux_core with the output registers, reset and enable.

Test Plan:
All scenarios use N=2, S=1.
1. Reset: rst=1 for 2 cycles with a=2'b11, select=1 -> result[1]=0, result[0]=0, lane_valid=2'b00.
2. Lane 0 sweep: en=1, select=0, a = 0,1,2,3 on consecutive cycles -> next cycle result[0] = 0,1,2,3, result[1]=0, lane_valid=2'b01.
3. Lane 1 sweep: en=1, select=1, a = 0,1,2,3 -> result[1] = 0,1,2,3, result[0]=0, lane_valid=2'b10.
4. Enable hold: load a=2, select=1, then en=0 while driving a=3, select=0 for 3 cycles -> result[1] stays 2, result[0] stays 0, lane_valid stays 2'b10.
5. Reset priority mid-stream: en=1, a=3, select=0, rst=1 on the same edge -> all lanes 0, lane_valid 0. Next edge with rst=0 -> result[0]=3.
6. With DEMUX_HOLD_LANES_EN defined: write a=1 to lane 0, then a=2 to lane 1 -> result[0]=1, result[1]=2, lane_valid=2'b11. Reset -> all 0.
